// File: rtl/pic_host_pkg.sv
// pic_host_pkg: shared types for the PIC host-side bus master.
//   state_t  - bus/acknowledge sequencer states
//   cmd_t    - command latched at acceptance (read flag, A0, write data)
//   CNT_W    - width of the cycle counter used for strobe/gap timing
//   cnt_load - counter preload for an N-cycle interval (counts N-1 down to 0)
package pic_host_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    ACK1    = 3'd4,
    ACK_GAP = 3'd5,
    ACK2    = 3'd6,
    RECOVER = 3'd7
  } state_t;

  typedef struct packed {
    logic       read;
    logic       a0;
    logic [7:0] data;
  } cmd_t;

  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/pic_int_sync.sv
// pic_int_sync: two-flop synchronizer for the PIC INT line.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (flops reset to 0)
//   d          - asynchronous input
//   q          - synchronized output, two clk cycles behind d
// Only instantiated when PIC_HOST_IF_INT_SYNC_EN is defined.
module pic_int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pic_host_if.sv
// pic_host_if: clocked host-side bus master for an 8259-compatible PIC.
// Turns single-word commands into timed CS/WR/RD/A0 bus cycles, answers INT
// with the two-pulse INTA sequence and buffers the captured vector (1 deep).
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             - command handshake
//   cmd_read, cmd_a0, cmd_data      - command fields (1 = read)
//   rsp_valid, rsp_data             - read data, one-cycle pulse
//   int_in                          - PIC INT output
//   vec_valid/vec_ready, vec_data   - vector handshake and captured vector
//   chip_select, write_flag,
//   read_flag, INTA                 - active-low bus strobes (registered)
//   A0, data_out, data_oe           - address select, write data, drive enable
//   data_in                         - bus read data
// Parameters: PULSE_CYCLES (strobe width, 1..15), GAP_CYCLES (recovery, 1..15).
// Build option: define PIC_HOST_IF_INT_SYNC_EN to pass int_in through a
// 2-flop synchronizer (adds 2 cycles of acknowledge latency); otherwise
// int_in must already be synchronous to clk.
module pic_host_if
  import pic_host_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       int_in,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic [7:0] vec_data,
  output logic       chip_select,
  output logic       write_flag,
  output logic       read_flag,
  output logic       A0,
  output logic       INTA,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in
);

  localparam logic [CNT_W-1:0] P_LOAD = cnt_load(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] G_LOAD = cnt_load(GAP_CYCLES);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  cmd_t             cmd, cmd_n;
  logic             int_seen, int_take, accept, cnt_zero, bus_n;

`ifdef PIC_HOST_IF_INT_SYNC_EN
  logic int_sync;

  pic_int_sync u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (int_in),
    .q     (int_sync)
  );

  always_comb int_seen = int_sync;
`else
  always_comb int_seen = int_in;
`endif

  // An interrupt wins over a simultaneous command; a full vector buffer
  // blocks new acknowledges but not commands.
  always_comb begin
    int_take  = (state == IDLE) && int_seen && !vec_valid;
    cmd_ready = rst_n && (state == IDLE) && !int_take;
    accept    = cmd_valid && cmd_ready;
    cnt_zero  = (cnt == '0);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cmd_n   = cmd;
    case (state)
      IDLE: begin
        if (int_take) begin
          state_n = ACK1;
          cnt_n   = P_LOAD;
        end else if (accept) begin
          state_n = SETUP;
          cmd_n   = {cmd_read, cmd_a0, cmd_data};
        end
      end
      SETUP: begin
        state_n = STROBE;
        cnt_n   = P_LOAD;
      end
      STROBE: begin
        if (cnt_zero) state_n = HOLD;
        else          cnt_n   = cnt - CNT_W'(1);
      end
      HOLD: begin
        state_n = RECOVER;
        cnt_n   = G_LOAD;
      end
      ACK1: begin
        if (cnt_zero) begin
          state_n = ACK_GAP;
          cnt_n   = G_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ACK_GAP: begin
        if (cnt_zero) begin
          state_n = ACK2;
          cnt_n   = P_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ACK2: begin
        if (cnt_zero) begin
          state_n = RECOVER;
          cnt_n   = G_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt_zero) state_n = IDLE;
        else          cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb bus_n = (state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD);

  // Bus outputs are decoded from the next state so that each output flop
  // already shows the value belonging to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd         <= '0;
      chip_select <= 1'b1;
      write_flag  <= 1'b1;
      read_flag   <= 1'b1;
      INTA        <= 1'b1;
      A0          <= 1'b0;
      data_out    <= '0;
      data_oe     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      vec_valid   <= 1'b0;
      vec_data    <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cmd         <= cmd_n;
      chip_select <= !bus_n;
      write_flag  <= !((state_n == STROBE) && !cmd_n.read);
      read_flag   <= !((state_n == STROBE) && cmd_n.read);
      INTA        <= !((state_n == ACK1) || (state_n == ACK2));
      A0          <= bus_n && cmd_n.a0;
      data_out    <= (bus_n && !cmd_n.read) ? cmd_n.data : '0;
      data_oe     <= bus_n && !cmd_n.read;
      rsp_valid   <= (state_n == HOLD) && cmd_n.read;

      if ((state == STROBE) && cnt_zero && cmd.read)
        rsp_data <= data_in;

      if ((state == ACK2) && cnt_zero) begin
        vec_data  <= data_in;
        vec_valid <= 1'b1;
      end else if (vec_valid && vec_ready) begin
        vec_valid <= 1'b0;
      end
    end
  end

endmodule
